// File: rtl/csr_trap_seq_pkg.sv
// Shared definitions for the machine-mode trap/return sequencer:
// CSR addresses, mstatus field positions, state and selection encodings.
package csr_trap_seq_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MBADADDR = 12'h343;

  localparam int unsigned MST_MIE    = 3;
  localparam int unsigned MST_MPIE   = 7;
  localparam int unsigned MST_MPP_LO = 11;
  localparam int unsigned MST_MPP_HI = 12;
  localparam int unsigned MST_SD     = 31;

  localparam logic [31:0] IRQ_CAUSE_MTI = 32'h8000_0007;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_T_MEPC   = 3'd1,
    ST_T_MCAUSE = 3'd2,
    ST_T_TVAL   = 3'd3,
    ST_T_MST    = 3'd4,
    ST_M_MST    = 3'd5,
    ST_M_EPC    = 3'd6,
    ST_REDIR    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_EXC  = 2'd1,
    SEL_IRQ  = 2'd2,
    SEL_MRET = 2'd3
  } sel_e;

  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
    logic [31:0] r;
    r                        = s;
    r[MST_MPIE]              = s[MST_MIE];
    r[MST_MIE]               = 1'b0;
    r[MST_MPP_HI:MST_MPP_LO] = 2'b11;
    r[MST_SD]                = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
    logic [31:0] r;
    r                        = s;
    r[MST_MIE]               = s[MST_MPIE];
    r[MST_MPIE]              = 1'b1;
    r[MST_MPP_HI:MST_MPP_LO] = 2'b11;
    r[MST_SD]                = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/csr_trap_seq_prio.sv
// Combinational request arbiter: exception > enabled timer interrupt > mret,
// producing the selected request kind and the mcause value to record.
module csr_trap_prio
  import csr_trap_seq_pkg::*;
#(
  parameter int unsigned       XLEN      = 32,
  parameter int unsigned       CAUSE_W   = 5,
  parameter logic [XLEN-1:0]   IRQ_CAUSE = IRQ_CAUSE_MTI
) (
  input  logic               exc_req,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic               irq_pend,
  input  logic               mtie,
  input  logic               mret_req,
  output sel_e               sel,
  output logic [XLEN-1:0]    cause
);

  always_comb begin
    sel   = SEL_NONE;
    cause = '0;
    if (exc_req) begin
      sel                 = SEL_EXC;
      cause[CAUSE_W-1:0]  = exc_cause;
    end else if (irq_pend && mtie) begin
      sel   = SEL_IRQ;
      cause = IRQ_CAUSE;
    end else if (mret_req) begin
      sel = SEL_MRET;
    end
  end

endmodule

// File: rtl/csr_trap_seq.sv
// Trap/return sequencer: accepts one request in IDLE, then walks the CSR file's
// single write port and registered read port, ending with a one-cycle PC redirect.
module csr_trap_seq
  import csr_trap_seq_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     CAUSE_W   = 5,
  parameter logic [XLEN-1:0] IRQ_CAUSE = IRQ_CAUSE_MTI
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exc_req,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic               irq_pend,
  input  logic               mtie,
  input  logic               mret_req,
  input  logic               freeze,
  input  logic [XLEN-1:0]    csr_mtvec,
  input  logic [XLEN-1:0]    csr_rddata,
  output logic               csr_wr_en,
  output logic [11:0]        csr_adr_wr,
  output logic [XLEN-1:0]    csr_wrdata,
  output logic [11:0]        csr_adr_rd,
  output logic               trap_ack,
  output logic               busy,
  output logic               pc_redirect,
  output logic [XLEN-1:0]    redirect_pc
);

  state_e          state_q, state_d;
  logic            mret_q;
  logic [XLEN-1:0] pc_q, tval_q, cause_q, epc_q;
  sel_e            sel;
  logic [XLEN-1:0] sel_cause;
  logic            accept;
  logic            wr_state;

  csr_trap_prio #(
    .XLEN      (XLEN),
    .CAUSE_W   (CAUSE_W),
    .IRQ_CAUSE (IRQ_CAUSE)
  ) u_prio (
    .exc_req   (exc_req),
    .exc_cause (exc_cause),
    .irq_pend  (irq_pend),
    .mtie      (mtie),
    .mret_req  (mret_req),
    .sel       (sel),
    .cause     (sel_cause)
  );

  // Accept is Mealy so trap_ack lands in the request cycle; gated by rst so reset forces it low.
  assign accept = rst && !freeze && (state_q == ST_IDLE) && (sel != SEL_NONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (accept) state_d = (sel == SEL_MRET) ? ST_M_MST : ST_T_MEPC;
      ST_T_MEPC:   state_d = ST_T_MCAUSE;
      ST_T_MCAUSE: state_d = ST_T_TVAL;
      ST_T_TVAL:   state_d = ST_T_MST;
      ST_T_MST:    state_d = ST_REDIR;
      ST_M_MST:    state_d = ST_M_EPC;
      ST_M_EPC:    state_d = ST_REDIR;
      ST_REDIR:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (freeze) state_d = state_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mret_q  <= 1'b0;
      pc_q    <= '0;
      tval_q  <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mret_q  <= (sel == SEL_MRET);
        pc_q    <= exc_pc;
        tval_q  <= (sel == SEL_IRQ) ? '0 : exc_tval;
        cause_q <= sel_cause;
      end
      if (state_q == ST_M_EPC && !freeze) epc_q <= csr_rddata;
    end
  end

  // Read address is decoded from the held state, so a frozen read state keeps presenting it.
  always_comb begin
    wr_state    = 1'b0;
    csr_adr_wr  = '0;
    csr_wrdata  = '0;
    csr_adr_rd  = '0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    trap_ack    = accept;
    busy        = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: if (rst && sel == SEL_MRET) csr_adr_rd = CSR_MSTATUS;
      ST_T_MEPC: begin
        wr_state   = 1'b1;
        csr_adr_wr = CSR_MEPC;
        csr_wrdata = pc_q;
      end
      ST_T_MCAUSE: begin
        wr_state   = 1'b1;
        csr_adr_wr = CSR_MCAUSE;
        csr_wrdata = cause_q;
      end
      ST_T_TVAL: begin
        wr_state   = 1'b1;
        csr_adr_wr = CSR_MBADADDR;
        csr_wrdata = tval_q;
        csr_adr_rd = CSR_MSTATUS;
      end
      ST_T_MST: begin
        wr_state   = 1'b1;
        csr_adr_wr = CSR_MSTATUS;
        csr_wrdata = mstatus_on_trap(csr_rddata);
      end
      ST_M_MST: begin
        wr_state   = 1'b1;
        csr_adr_wr = CSR_MSTATUS;
        csr_wrdata = mstatus_on_mret(csr_rddata);
        csr_adr_rd = CSR_MEPC;
      end
      ST_M_EPC: ;
      ST_REDIR: begin
        pc_redirect = !freeze;
        redirect_pc = mret_q ? epc_q : csr_mtvec;
      end
      default: ;
    endcase
    csr_wr_en = wr_state && !freeze;
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed and randomized bench for csr_trap_seq with a behavioural CSR file and
// a transaction-level model of the expected write list, redirect target and timing.
module tb_csr_trap_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exc_req = 1'b0;
  logic [4:0]  exc_cause = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_tval = '0;
  logic        irq_pend = 1'b0;
  logic        mtie = 1'b0;
  logic        mret_req = 1'b0;
  logic        freeze = 1'b0;
  logic [31:0] csr_mtvec = '0;
  logic [31:0] csr_rddata;
  logic        csr_wr_en;
  logic [11:0] csr_adr_wr;
  logic [31:0] csr_wrdata;
  logic [11:0] csr_adr_rd;
  logic        trap_ack;
  logic        busy;
  logic        pc_redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  csr_trap_seq #(
    .XLEN      (32),
    .CAUSE_W   (5),
    .IRQ_CAUSE (32'h8000_0007)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .exc_req     (exc_req),
    .exc_cause   (exc_cause),
    .exc_pc      (exc_pc),
    .exc_tval    (exc_tval),
    .irq_pend    (irq_pend),
    .mtie        (mtie),
    .mret_req    (mret_req),
    .freeze      (freeze),
    .csr_mtvec   (csr_mtvec),
    .csr_rddata  (csr_rddata),
    .csr_wr_en   (csr_wr_en),
    .csr_adr_wr  (csr_adr_wr),
    .csr_wrdata  (csr_wrdata),
    .csr_adr_rd  (csr_adr_rd),
    .trap_ack    (trap_ack),
    .busy        (busy),
    .pc_redirect (pc_redirect),
    .redirect_pc (redirect_pc)
  );

  // Behavioural CSR file: backdoor preload, DUT write port, read port frozen with the pipeline.
  logic [31:0] csr_mem [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_adr = '0;
  logic [31:0] bd_dat = '0;

  always @(posedge clk) begin
    if (bd_we) csr_mem[bd_adr] <= bd_dat;
    if (csr_wr_en) csr_mem[csr_adr_wr] <= csr_wrdata;
    if (!freeze) csr_rddata <= csr_mem[csr_adr_rd];
  end

  logic [43:0] wr_log [$];
  always @(negedge clk) if (csr_wr_en) wr_log.push_back({csr_adr_wr, csr_wrdata});

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_trap(input logic [31:0] s);
    return (s & ~32'h8000_1888) | (((s >> 3) & 32'h1) << 7) | 32'h1800;
  endfunction

  function automatic logic [31:0] ref_mret(input logic [31:0] s);
    return (s & ~32'h8000_1888) | (((s >> 7) & 32'h1) << 3) | 32'h0080 | 32'h1800;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_csr(input logic [11:0] adr, input logic [31:0] dat);
    bd_we  = 1'b1;
    bd_adr = adr;
    bd_dat = dat;
    step();
    bd_we  = 1'b0;
  endtask

  task automatic drop_reqs();
    exc_req  = 1'b0;
    irq_pend = 1'b0;
    mtie     = 1'b0;
    mret_req = 1'b0;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (trap_ack) begin
        ok = 1'b1;
        break;
      end
    end
    check("ack_seen", ok, 1);
  endtask

  // Entered at the negedge of the accept cycle; leaves at the negedge of the cycle after REDIR.
  task automatic run_body(input bit is_mret, input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] tval, input logic [31:0] mst, input logic [31:0] tgt,
                          input int fmode, input bit keep_mret);
    logic [43:0] exp_q [$];
    logic [31:0] rpc;
    int start, base, nfz, k;
    bit found;
    start = wr_log.size();
    if (!is_mret) begin
      exp_q.push_back({12'h341, pc});
      exp_q.push_back({12'h342, cause});
      exp_q.push_back({12'h343, tval});
      exp_q.push_back({12'h300, ref_trap(mst)});
      base = 5;
    end else begin
      exp_q.push_back({12'h300, ref_mret(mst)});
      base = 3;
    end
    nfz = 0;
    found = 1'b0;
    rpc = '0;
    for (k = 1; k <= 40; k++) begin
      step();
      if (k == 1) begin
        exc_req  = 1'b0;
        irq_pend = 1'b0;
        mtie     = 1'b0;
        if (!keep_mret) mret_req = 1'b0;
      end
      case (fmode)
        1:       freeze = ($urandom_range(0, 3) == 0);
        2:       freeze = (k >= 2 && k <= 4);
        default: freeze = 1'b0;
      endcase
      @(negedge clk);
      if (freeze) begin
        nfz++;
        check("frz_quiet", {csr_wr_en, pc_redirect}, 0);
      end
      check("busy_seq", busy, 1);
      if (pc_redirect) begin
        found = 1'b1;
        rpc = redirect_pc;
        break;
      end
    end
    check("redir_seen", found, 1);
    check("redir_delay", k, base + nfz);
    check("redir_pc", rpc, tgt);
    step();
    freeze = 1'b0;
    @(negedge clk);
    check("idle_after", {busy, pc_redirect}, 0);
    check("wr_cnt", wr_log.size() - start, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (start + i < wr_log.size()) check($sformatf("wr%0d", i), wr_log[start + i], exp_q[i]);
  endtask

  initial begin
    bit ok;
    int s0, acks;
    logic [31:0] r_pc, r_tval, r_mst, r_epc, r_mtvec;
    logic [4:0]  r_cs;
    bit r_e, r_i, r_m, r_r;
    int r_fm;

    exc_req  = 1'b1;
    mret_req = 1'b1;
    #2;
    check("rst_ctl", {csr_wr_en, trap_ack, busy, pc_redirect, csr_adr_wr, csr_adr_rd}, 0);
    check("rst_data", {csr_wrdata, redirect_pc}, 0);
    step();
    drop_reqs();
    step();
    rst = 1'b1;
    step();

    // Exception with the reference values
    set_csr(12'h300, 32'h8);
    csr_mtvec = 32'h200;
    exc_cause = 5'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD; exc_req = 1'b1;
    wait_ack(ok);
    if (ok) run_body(0, 32'h100, 32'h2, 32'hDEAD, 32'h8, 32'h200, 0, 0); else drop_reqs();

    // Enabled timer interrupt: tval forced to zero
    step();
    set_csr(12'h300, 32'h88);
    csr_mtvec = 32'h400;
    exc_pc = 32'h340; exc_tval = 32'h1234; irq_pend = 1'b1; mtie = 1'b1;
    wait_ack(ok);
    if (ok) run_body(0, 32'h340, 32'h8000_0007, 32'h0, 32'h88, 32'h400, 0, 0); else drop_reqs();

    // Masked interrupt: nothing happens
    step();
    irq_pend = 1'b1; mtie = 1'b0;
    s0 = wr_log.size();
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (trap_ack) acks++;
    end
    check("irq_masked_ack", acks, 0);
    check("irq_masked_wr", wr_log.size() - s0, 0);
    check("irq_masked_busy", busy, 0);
    step();
    drop_reqs();

    // Exception and mret together, mret held through the exception
    set_csr(12'h300, 32'h80);
    csr_mtvec = 32'h300;
    exc_cause = 5'd11; exc_pc = 32'h2000; exc_tval = 32'h0; exc_req = 1'b1; mret_req = 1'b1;
    wait_ack(ok);
    if (ok) begin
      run_body(0, 32'h2000, 32'd11, 32'h0, 32'h80, 32'h300, 0, 1);
      check("mret_follow_ack", trap_ack, 1);
      if (trap_ack) run_body(1, 32'h0, 32'h0, 32'h0, ref_trap(32'h80), 32'h2000, 0, 0);
      else drop_reqs();
    end else drop_reqs();

    // Plain mret
    step();
    set_csr(12'h300, 32'h1880);
    set_csr(12'h341, 32'h104);
    mret_req = 1'b1;
    wait_ack(ok);
    if (ok) run_body(1, 32'h0, 32'h0, 32'h0, 32'h1880, 32'h104, 0, 0); else drop_reqs();

    // Three-cycle freeze during the mcause write
    step();
    set_csr(12'h300, 32'h0);
    csr_mtvec = 32'h600;
    exc_cause = 5'd7; exc_pc = 32'h500; exc_tval = 32'hBEEF; exc_req = 1'b1;
    wait_ack(ok);
    if (ok) run_body(0, 32'h500, 32'h7, 32'hBEEF, 32'h0, 32'h600, 2, 0); else drop_reqs();

    // Asynchronous reset while the mbadaddr write is pending
    step();
    set_csr(12'h300, 32'h8);
    csr_mtvec = 32'h700;
    exc_cause = 5'd5; exc_pc = 32'h400; exc_tval = 32'h44; exc_req = 1'b1;
    wait_ack(ok);
    s0 = wr_log.size();
    step();
    drop_reqs();
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check("arst_ctl", {csr_wr_en, trap_ack, busy, pc_redirect, csr_adr_wr, csr_adr_rd}, 0);
    check("arst_data", {csr_wrdata, redirect_pc}, 0);
    check("arst_pre_wr", wr_log.size() - s0, 2);
    step();
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("arst_no_wr", wr_log.size() - s0, 2);
    check("arst_idle", busy, 0);

    // Randomized requests against the transaction model
    for (int n = 0; n < 40; n++) begin
      step();
      r_pc = $urandom; r_tval = $urandom; r_mst = $urandom; r_epc = $urandom; r_mtvec = $urandom;
      r_cs = 5'($urandom_range(0, 31));
      r_e = ($urandom_range(0, 2) == 0);
      r_i = ($urandom_range(0, 1) == 0);
      r_m = ($urandom_range(0, 1) == 0);
      r_r = ($urandom_range(0, 2) == 0);
      r_fm = $urandom_range(0, 1);
      set_csr(12'h300, r_mst);
      set_csr(12'h341, r_epc);
      csr_mtvec = r_mtvec;
      exc_cause = r_cs; exc_pc = r_pc; exc_tval = r_tval;
      exc_req = r_e; irq_pend = r_i; mtie = r_m; mret_req = r_r;
      if (!r_e && !(r_i && r_m) && !r_r) begin
        s0 = wr_log.size();
        acks = 0;
        repeat (4) begin
          @(negedge clk);
          if (trap_ack) acks++;
        end
        check("rnd_none_ack", acks, 0);
        check("rnd_none_wr", wr_log.size() - s0, 0);
        step();
        drop_reqs();
      end else begin
        wait_ack(ok);
        if (!ok) drop_reqs();
        else if (r_e) run_body(0, r_pc, {27'b0, r_cs}, r_tval, r_mst, r_mtvec, r_fm, 0);
        else if (r_i && r_m) run_body(0, r_pc, 32'h8000_0007, 32'h0, r_mst, r_mtvec, r_fm, 0);
        else run_body(1, 32'h0, 32'h0, 32'h0, r_mst, r_epc, r_fm, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
